decode_stage: RTL and testbench

//  Decode stage feeding execute: latches the fetched word, splits fields, reads a 64-entry

---
 rtl/decode_stage_pkg.sv | 111 +++++++++++
 rtl/regfile64.sv | 40 ++++
 rtl/decode_stage.sv | 123 ++++++++++++
 tb/tb_decode_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage_pkg
//  Description : Opcodes, D/E register layout and the instruction field decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package decode_stage_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_FPU   = 6'h11;
    localparam logic [5:0] OP_IN    = 6'h1A;
    localparam logic [5:0] OP_OUT   = 6'h1B;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_LW_S  = 6'h31;
    localparam logic [5:0] OP_SW_S  = 6'h39;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] REG_RA   = 6'd31;
    localparam int         FPR_BIT  = 5;

    typedef enum logic [1:0] {
        OPT_IJ    = 2'b00,
        OPT_INT_R = 2'b01,
        OPT_FPU   = 2'b10
    } op_type_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  instr;
        op_type_e    op_type;
        logic [31:0] s;
        logic [31:0] t;
        logic [5:0]  rs;
        logic [5:0]  rt;
        logic [5:0]  rd;
        logic [31:0] imm;
        logic        branch;
        logic        jump;
        logic        is_jr;
        logic        start;
        logic        hazard;
    } de_reg_t;

    // Field split only; operand values and start are filled in by the stage.
    function automatic de_reg_t decode_word(input logic [31:0] w, input logic [31:0] w_pc);
        de_reg_t    d;
        logic [5:0] opc;
        d       = '0;
        opc     = w[31:26];
        d.pc    = w_pc;
        d.instr = opc;
        d.rs    = {1'b0, w[25:21]};
        d.rt    = {1'b0, w[20:16]};
        d.imm   = {{16{w[15]}}, w[15:0]};
        case (opc)
            OP_RTYPE: begin
                d.op_type = OPT_INT_R;
                d.instr   = w[5:0];
                if (w[5:0] == FN_JR)
                    d.is_jr = 1'b1;
                else
                    d.rd = {1'b0, w[15:11]};
            end
            OP_FPU: begin
                d.op_type        = OPT_FPU;
                d.instr          = w[5:0];
                d.rs[FPR_BIT]    = 1'b1;
                d.rt[FPR_BIT]    = 1'b1;
                d.rd             = {1'b1, w[15:11]};
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                d.imm = {16'h0, w[15:0]};
                d.rd  = {1'b0, w[20:16]};
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LUI, OP_LW, OP_IN: begin
                d.rd = {1'b0, w[20:16]};
            end
            OP_LW_S: begin
                d.rt[FPR_BIT] = 1'b1;
                d.rd          = {1'b1, w[20:16]};
            end
            OP_SW_S: d.rt[FPR_BIT] = 1'b1;
            OP_J: begin
                d.jump = 1'b1;
                d.imm  = {6'h0, w[25:0]};
            end
            OP_JAL: begin
                d.jump = 1'b1;
                d.rd   = REG_RA;
                d.imm  = {6'h0, w[25:0]};
            end
            OP_BEQ, OP_BNE: d.branch = 1'b1;
            default: ;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile64.sv
`default_nettype none
// ============================================================================
//  Module      : regfile64
//  Description : 64x32 register file, 2 async reads, 1 sync write, write-first bypass.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile64 (
    input  logic        clk,
    input  logic        rstn,
    input  logic [5:0]  raddr_a,
    input  logic [5:0]  raddr_b,
    output logic [31:0] rdata_a,
    output logic [31:0] rdata_b,
    input  logic        we,
    input  logic [5:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] r_mem [64];
    logic        w_wr_ok;

    // Index 0 is GPR r0: never written, always reads zero. Index 32 (f0) is ordinary.
    assign w_wr_ok = we && (waddr != 6'd0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 64; i++)
                r_mem[i] <= '0;
        end else if (w_wr_ok) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == 6'd0)                 ? 32'h0 :
                     (w_wr_ok && (waddr == raddr_a))   ? wdata : r_mem[raddr_a];
    assign rdata_b = (raddr_b == 6'd0)                 ? 32'h0 :
                     (w_wr_ok && (waddr == raddr_b))   ? wdata : r_mem[raddr_b];

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage
//  Description : Decode stage with register file read, load-use bubble, UART hold
//                and redirect squash, registered into the D/E pipeline register.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_instr,
    input  logic        if_valid,
    input  logic        uart_state,
    input  logic        redirect,
    input  logic [31:0] ew_d,
    input  logic [1:0]  ew_rw,
    input  logic [4:0]  ew_rd,
    output logic        stall_if,
    output logic [31:0] pc,
    output logic [5:0]  instr,
    output logic [1:0]  op_type,
    output logic [31:0] de_s,
    output logic [31:0] de_t,
    output logic [5:0]  de_rs,
    output logic [5:0]  de_rt,
    output logic [5:0]  de_rd,
    output logic [31:0] imm,
    output logic        branch,
    output logic        jump,
    output logic        is_jr,
    output logic        start,
    output logic        hazard
);

    de_reg_t     r_de;
    de_reg_t     w_fields;
    de_reg_t     w_dec;
    de_reg_t     w_next;
    logic [31:0] w_rf_a;
    logic [31:0] w_rf_b;
    logic        w_we;
    logic [5:0]  w_waddr;
    logic        w_de_is_load;
    logic        w_load_use;

    assign w_fields = decode_word(if_instr, if_pc);

    // ew_rw=2'b11 is treated as a GPR write: FPR only when bit1 alone is set.
    assign w_we    = |ew_rw;
    assign w_waddr = {ew_rw[1] & ~ew_rw[0], ew_rd};

    regfile64 u_regfile (
        .clk     (clk),
        .rstn    (rstn),
        .raddr_a (w_fields.rs),
        .raddr_b (w_fields.rt),
        .rdata_a (w_rf_a),
        .rdata_b (w_rf_b),
        .we      (w_we),
        .waddr   (w_waddr),
        .wdata   (ew_d)
    );

    always_comb begin
        w_dec       = w_fields;
        w_dec.s     = ((w_fields.op_type == OPT_IJ) && (w_fields.instr == OP_JAL)) ?
                      if_pc + 32'd4 : w_rf_a;
        w_dec.t     = w_rf_b;
        w_dec.start = 1'b1;
    end

    assign w_de_is_load = (r_de.op_type == OPT_IJ) &&
                          ((r_de.instr == OP_LW) || (r_de.instr == OP_LW_S));
    assign w_load_use   = if_valid && w_de_is_load && (r_de.rd != 6'd0) &&
                          ((w_fields.rs == r_de.rd) || (w_fields.rt == r_de.rd));

    always_comb begin
        w_next = '0;
        if (redirect) begin
            w_next = '0;
        end else if (uart_state) begin
            w_next       = r_de;
            w_next.start = 1'b0;
        end else if (w_load_use) begin
            w_next.hazard = 1'b1;
        end else if (if_valid) begin
            w_next = w_dec;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_de    <= '0;
            r_de.pc <= RESET_PC;
        end else begin
            r_de    <= w_next;
        end
    end

    assign stall_if = rstn && !redirect && (uart_state || w_load_use);

    assign pc      = r_de.pc;
    assign instr   = r_de.instr;
    assign op_type = r_de.op_type;
    assign de_s    = r_de.s;
    assign de_t    = r_de.t;
    assign de_rs   = r_de.rs;
    assign de_rt   = r_de.rt;
    assign de_rd   = r_de.rd;
    assign imm     = r_de.imm;
    assign branch  = r_de.branch;
    assign jump    = r_de.jump;
    assign is_jr   = r_de.is_jr;
    assign start   = r_de.start;
    assign hazard  = r_de.hazard;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_stage
//  Description : Directed and random stimulus for decode_stage against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;
    import decode_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] if_pc, if_instr, ew_d;
    logic        if_valid, uart_state, redirect;
    logic [1:0]  ew_rw;
    logic [4:0]  ew_rd;
    logic        stall_if, branch, jump, is_jr, start, hazard;
    logic [31:0] pc, de_s, de_t, imm;
    logic [5:0]  instr, de_rs, de_rt, de_rd;
    logic [1:0]  op_type;

    always #5 clk = ~clk;

    decode_stage #(.RESET_PC(32'h0)) dut (
        .clk(clk), .rstn(rstn), .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid),
        .uart_state(uart_state), .redirect(redirect), .ew_d(ew_d), .ew_rw(ew_rw),
        .ew_rd(ew_rd), .stall_if(stall_if), .pc(pc), .instr(instr), .op_type(op_type),
        .de_s(de_s), .de_t(de_t), .de_rs(de_rs), .de_rt(de_rt), .de_rd(de_rd), .imm(imm),
        .branch(branch), .jump(jump), .is_jr(is_jr), .start(start), .hazard(hazard)
    );

    typedef struct {
        logic [31:0] pc;
        logic [5:0]  instr;
        logic [1:0]  op_type;
        logic [31:0] s, t, imm;
        logic [5:0]  rs, rt, rd;
        logic        branch, jump, is_jr, start, hazard;
    } exp_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_rf [64];
    exp_t        m_de;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t m_nop();
        exp_t e;
        e = '{default: '0};
        return e;
    endfunction

    function automatic logic [5:0] m_widx();
        return ew_rw[0] ? {1'b0, ew_rd} : {1'b1, ew_rd};
    endfunction

    function automatic logic [31:0] m_read(input logic [5:0] idx);
        if (idx == 6'd0) return 32'h0;
        if (ew_rw != 2'b00 && m_widx() == idx) return ew_d;
        return m_rf[idx];
    endfunction

    function automatic exp_t m_decode(input logic [31:0] w, input logic [31:0] wpc);
        exp_t       e;
        logic [5:0] opc;
        logic       fpu, rtype;
        e     = '{default: '0};
        opc   = w[31:26];
        fpu   = (opc == OP_FPU);
        rtype = (opc == OP_RTYPE);
        e.pc      = wpc;
        e.start   = 1'b1;
        e.op_type = rtype ? 2'b01 : (fpu ? 2'b10 : 2'b00);
        e.instr   = (rtype || fpu) ? w[5:0] : opc;
        e.rs      = {fpu, w[25:21]};
        e.rt      = {fpu || opc == OP_LW_S || opc == OP_SW_S, w[20:16]};
        if (rtype)                e.rd = (w[5:0] == FN_JR) ? 6'd0 : {1'b0, w[15:11]};
        else if (fpu)             e.rd = {1'b1, w[15:11]};
        else if (opc inside {OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI,
                             OP_LUI, OP_LW, OP_IN})
                                  e.rd = {1'b0, w[20:16]};
        else if (opc == OP_LW_S)  e.rd = {1'b1, w[20:16]};
        else if (opc == OP_JAL)   e.rd = 6'd31;
        if (opc inside {OP_ANDI, OP_ORI, OP_XORI}) e.imm = {16'h0, w[15:0]};
        else if (opc inside {OP_J, OP_JAL})        e.imm = {6'h0, w[25:0]};
        else                                       e.imm = {{16{w[15]}}, w[15:0]};
        e.branch = opc inside {OP_BEQ, OP_BNE};
        e.jump   = opc inside {OP_J, OP_JAL};
        e.is_jr  = rtype && (w[5:0] == FN_JR);
        e.s      = (opc == OP_JAL) ? wpc + 32'd4 : m_read(e.rs);
        e.t      = m_read(e.rt);
        return e;
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] opc, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] k);
        return {opc, rs, rt, k};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
    endfunction

    task automatic compare_all();
        if (m_de.start) chk("pc", pc, m_de.pc);
        chk("instr",   32'(instr),   32'(m_de.instr));
        chk("op_type", 32'(op_type), 32'(m_de.op_type));
        chk("de_s",    de_s,         m_de.s);
        chk("de_t",    de_t,         m_de.t);
        chk("de_rs",   32'(de_rs),   32'(m_de.rs));
        chk("de_rt",   32'(de_rt),   32'(m_de.rt));
        chk("de_rd",   32'(de_rd),   32'(m_de.rd));
        chk("imm",     imm,          m_de.imm);
        chk("flags",   {27'h0, branch, jump, is_jr, start, hazard},
            {27'h0, m_de.branch, m_de.jump, m_de.is_jr, m_de.start, m_de.hazard});
    endtask

    task automatic step(input logic v, input logic [31:0] wpc, input logic [31:0] w,
                        input logic u, input logic r, input logic [1:0] rw,
                        input logic [4:0] wrd, input logic [31:0] wd);
        exp_t dec, nxt;
        logic lu;
        @(negedge clk);
        if_valid = v; if_pc = wpc; if_instr = w; uart_state = u; redirect = r;
        ew_rw = rw; ew_rd = wrd; ew_d = wd;
        #1;
        dec = m_decode(w, wpc);
        lu  = v && m_de.op_type == 2'b00 && (m_de.instr == OP_LW || m_de.instr == OP_LW_S) &&
              m_de.rd != 6'd0 && (dec.rs == m_de.rd || dec.rt == m_de.rd);
        chk("stall_if", 32'(stall_if), 32'(!r && (u || lu)));
        if (r)       nxt = m_nop();
        else if (u)  begin nxt = m_de; nxt.start = 1'b0; end
        else if (lu) begin nxt = m_nop(); nxt.hazard = 1'b1; end
        else if (v)  nxt = dec;
        else         nxt = m_nop();
        @(posedge clk);
        #1;
        if (rw != 2'b00 && m_widx() != 6'd0) m_rf[m_widx()] = wd;
        m_de = nxt;
        compare_all();
    endtask

    logic [5:0] ops [18] = '{OP_RTYPE, OP_FPU, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI,
                             OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW, OP_LW_S, OP_SW_S,
                             OP_IN, OP_OUT};

    initial begin
        logic [31:0] w;
        rstn = 1'b0; if_pc = '0; if_instr = '0; if_valid = 1'b0; uart_state = 1'b0;
        redirect = 1'b0; ew_d = '0; ew_rw = 2'b00; ew_rd = '0;
        for (int i = 0; i < 64; i++) m_rf[i] = '0;
        m_de = m_nop();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        chk("reset_stall", 32'(stall_if), 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        // ADDI r1,r0,5 ; ADD r2,r1,r1 with r1 written back while ADD decodes
        step(1, 32'h0, enc_i(OP_ADDI, 0, 1, 16'd5), 0, 0, 2'b00, 0, 0);
        step(1, 32'h4, enc_r(1, 1, 2, 6'h20), 0, 0, 2'b01, 1, 32'd5);
        chk("t1_bypass_s", de_s, 32'd5);
        chk("t1_bypass_t", de_t, 32'd5);
        step(1, 32'h8, enc_r(2, 0, 5, 6'h20), 0, 0, 2'b01, 2, 32'd10);
        chk("t1_r2", de_s, 32'd10);

        // Load-use: one bubble then retry
        step(1, 32'hC, enc_i(OP_LW, 0, 3, 16'd0), 0, 0, 2'b00, 0, 0);
        step(1, 32'h10, enc_r(3, 3, 4, 6'h20), 0, 0, 2'b00, 0, 0);
        chk("t2_hazard", 32'(hazard), 32'h1);
        step(1, 32'h10, enc_r(3, 3, 4, 6'h20), 0, 0, 2'b01, 3, 32'h77);
        chk("t2_retry_start", 32'(start), 32'h1);

        // OUT held seven cycles by uart_state
        step(1, 32'h14, enc_i(OP_OUT, 4, 0, 16'd0), 0, 0, 2'b00, 0, 0);
        for (int i = 0; i < 7; i++) begin
            step(1, 32'h18, enc_r(1, 2, 6, 6'h20), 1, 0, 2'b00, 0, 0);
            chk("t3_hold_pc", pc, 32'h14);
        end
        step(1, 32'h18, enc_r(1, 2, 6, 6'h20), 0, 0, 2'b00, 0, 0);
        chk("t3_resume_pc", pc, 32'h18);

        // Redirect wins over a pending load-use
        step(1, 32'h1C, enc_i(OP_LW, 0, 6, 16'd4), 0, 0, 2'b00, 0, 0);
        step(1, 32'h20, enc_r(6, 6, 7, 6'h20), 0, 1, 2'b00, 0, 0);
        chk("t4_hazard", 32'(hazard), 32'h0);

        // JAL 0x40 at 0x100
        step(1, 32'h100, {OP_JAL, 26'h40}, 0, 0, 2'b00, 0, 0);
        chk("t5_rd", 32'(de_rd), 32'd31);
        chk("t5_s", de_s, 32'h104);
        chk("t5_imm", imm, 32'h40);

        // Asynchronous reset in the middle of a hold
        step(1, 32'h104, enc_i(OP_ADDI, 1, 8, 16'hFFFF), 0, 0, 2'b00, 0, 0);
        step(1, 32'h108, enc_r(8, 1, 9, 6'h20), 1, 0, 2'b00, 0, 0);
        @(negedge clk);
        #2;
        rstn = 1'b0; if_valid = 1'b0; uart_state = 1'b0; redirect = 1'b0; ew_rw = 2'b00;
        #1;
        chk("t6_pc", pc, 32'h0);
        chk("t6_rd", 32'(de_rd), 32'h0);
        chk("t6_s", de_s, 32'h0);
        chk("t6_start", 32'(start), 32'h0);
        chk("t6_stall", 32'(stall_if), 32'h0);
        for (int i = 0; i < 64; i++) m_rf[i] = '0;
        m_de = m_nop();
        @(negedge clk);
        rstn = 1'b1;
        step(1, 32'h0, enc_r(1, 8, 10, 6'h20), 0, 0, 2'b00, 0, 0);
        chk("t6_first_start", 32'(start), 32'h1);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            w = {ops[$urandom_range(0, 17)], 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 16'($urandom)};
            w[15:11] = 5'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) w[5:0] = FN_JR;
            step($urandom_range(0, 7) != 0, {$urandom, 2'b00} & 32'hFFFF_FFFC, w,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                 2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
